// File: rtl/ipg_pkg.sv
// Shared definitions for the TX inter-packet-gap sideband scheduler:
// block type codes, request header codes, default message geometry and
// the scheduler state / source encodings.
package ipg_pkg;

  localparam logic [7:0] BLOCK_TYPE_IDLE = 8'h00;
  localparam logic [7:0] BLOCK_TYPE_CTRL = 8'h1e;
  localparam logic [7:0] BLOCK_TYPE_TERM = 8'h87;

  localparam logic [7:0] READ_REQ  = 8'h00;
  localparam logic [7:0] WRITE_REQ = 8'h01;

  localparam int HDR_WIDTH  = 8;
  localparam int REQ_WIDTH  = HDR_WIDTH + 64;
  localparam int MSG_WIDTH  = 520;
  localparam int CHUNK_BITS = 56;
  localparam int REM_W      = 10;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;
  typedef enum logic {SRC_REQ = 1'b0, SRC_REP = 1'b1} src_t;

endpackage

// File: rtl/ipg_tx_sched_if.sv
// Bus bundle of the IPG scheduler: request and reply message handshakes,
// PCS idle-slot offer and the outgoing control-block stream.
//  master : message sources / PCS side (drives messages and slot offers)
//  slave  : the scheduler (drives ready and tx_ipg_*)
interface ipg_tx_sched_if #(
  parameter int REQ_WIDTH = 72,
  parameter int MSG_WIDTH = 520
);
  logic                 req_valid;
  logic                 req_ready;
  logic [REQ_WIDTH-1:0] req_data;
  logic                 rep_valid;
  logic                 rep_ready;
  logic [MSG_WIDTH-1:0] rep_data;
  logic                 slot_avail;
  logic [5:0]           slot_bits;
  logic                 tx_ipg_valid;
  logic [63:0]          tx_ipg_data;
  logic [5:0]           tx_ipg_len;
  logic                 tx_ipg_last;
  logic                 tx_ipg_src;

  modport master (
    output req_valid, req_data, rep_valid, rep_data, slot_avail, slot_bits,
    input  req_ready, rep_ready,
    input  tx_ipg_valid, tx_ipg_data, tx_ipg_len, tx_ipg_last, tx_ipg_src
  );

  modport slave (
    input  req_valid, req_data, rep_valid, rep_data, slot_avail, slot_bits,
    output req_ready, rep_ready,
    output tx_ipg_valid, tx_ipg_data, tx_ipg_len, tx_ipg_last, tx_ipg_src
  );
endinterface

// File: rtl/ipg_rr_arb2.sv
// Two-way round-robin arbiter.
//  clk, rst_n : clock, synchronous active-low reset
//  valid[1:0] : {reply, request} pending
//  upd        : message finished this cycle; upd_src = its source
//  gnt_any    : some source pending
//  gnt        : granted source (meaningful when gnt_any)
module ipg_rr_arb2 import ipg_pkg::*; (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       upd,
  input  src_t       upd_src,
  output logic       gnt_any,
  output src_t       gnt
);
  // Source preferred on a tie; starts on the request side.
  src_t ptr;

  always_comb begin
    gnt_any = |valid;
    if (valid == 2'b11) gnt = ptr;
    else                gnt = valid[1] ? SRC_REP : SRC_REQ;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)   ptr <= SRC_REQ;
    else if (upd) ptr <= (upd_src == SRC_REQ) ? SRC_REP : SRC_REQ;
  end
endmodule

// File: rtl/ipg_tx_sched.sv
// TX IPG sideband scheduler: picks a request or reply message round-robin,
// then cuts it into 64-bit control blocks (type 0x1e) sized to each idle
// slot the PCS offers. A granted message is never interleaved.
//  clk, rst_n : clock, synchronous active-low reset
//  bus        : message handshakes, slot offer, tx_ipg_* chunk stream
//  busy       : a message is in flight
module ipg_tx_sched import ipg_pkg::*; #(
  parameter int HDR_WIDTH  = ipg_pkg::HDR_WIDTH,
  parameter int REQ_WIDTH  = HDR_WIDTH + 64,
  parameter int MSG_WIDTH  = ipg_pkg::MSG_WIDTH,
  parameter int CHUNK_BITS = ipg_pkg::CHUNK_BITS
) (
  input  logic           clk,
  input  logic           rst_n,
  ipg_tx_sched_if.slave  bus,
  output logic           busy
);
  state_t                state;
  src_t                  src;
  logic [MSG_WIDTH-1:0]  shift_reg;
  logic [REM_W-1:0]      remaining;

  logic                  gnt_any;
  src_t                  gnt;
  logic                  open;
  logic                  accept;
  logic                  fire;
  logic                  last_chunk;
  logic [5:0]            slot_n;
  logic [5:0]            n;
  logic [CHUNK_BITS-1:0] mask;
  logic [CHUNK_BITS-1:0] head;

  ipg_rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   ({bus.rep_valid, bus.req_valid}),
    .upd     (last_chunk),
    .upd_src (src),
    .gnt_any (gnt_any),
    .gnt     (gnt)
  );

  // The cycle carrying the last chunk is the mandatory bubble: no accept.
  assign open          = rst_n && (state == IDLE) && !bus.tx_ipg_last && gnt_any;
  assign bus.req_ready = open && (gnt == SRC_REQ);
  assign bus.rep_ready = open && (gnt == SRC_REP);
  assign accept        = (bus.req_valid && bus.req_ready) || (bus.rep_valid && bus.rep_ready);
  assign busy          = (state == SEND);

  always_comb begin
    slot_n     = (bus.slot_bits > 6'(CHUNK_BITS)) ? 6'(CHUNK_BITS) : bus.slot_bits;
    n          = ({4'b0, slot_n} > remaining) ? remaining[5:0] : slot_n;
    fire       = (state == SEND) && bus.slot_avail && (bus.slot_bits != 6'd0);
    last_chunk = fire && ({4'b0, n} == remaining);
    // Top n bits of the window pass, the rest of the payload field is zero.
    mask       = ~({CHUNK_BITS{1'b1}} >> n);
    head       = shift_reg[MSG_WIDTH-1 -: CHUNK_BITS] & mask;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      src              <= SRC_REQ;
      shift_reg        <= '0;
      remaining        <= '0;
      bus.tx_ipg_valid <= 1'b0;
      bus.tx_ipg_data  <= '0;
      bus.tx_ipg_len   <= '0;
      bus.tx_ipg_last  <= 1'b0;
      bus.tx_ipg_src   <= 1'b0;
    end else begin
      bus.tx_ipg_valid <= 1'b0;
      bus.tx_ipg_data  <= '0;
      bus.tx_ipg_len   <= '0;
      bus.tx_ipg_last  <= 1'b0;
      bus.tx_ipg_src   <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          if (gnt == SRC_REP) begin
            shift_reg <= bus.rep_data;
            remaining <= REM_W'(MSG_WIDTH);
          end else begin
            shift_reg <= {bus.req_data, {(MSG_WIDTH-REQ_WIDTH){1'b0}}};
            remaining <= REM_W'(REQ_WIDTH);
          end
          src   <= gnt;
          state <= SEND;
        end
        SEND: if (fire) begin
          bus.tx_ipg_valid <= 1'b1;
          bus.tx_ipg_data  <= {head, BLOCK_TYPE_CTRL};
          bus.tx_ipg_len   <= n;
          bus.tx_ipg_last  <= last_chunk;
          bus.tx_ipg_src   <= src;
          shift_reg        <= shift_reg << n;
          remaining        <= remaining - {4'b0, n};
          if (last_chunk) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ipg_tx_sched.sv
// Directed bench for ipg_tx_sched: reset state, request/reply chunking,
// round-robin ties, odd slot sizes, reset mid-message and a long stall.
module tb_ipg_tx_sched;
  import ipg_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  always #5 clk = ~clk;

  ipg_tx_sched_if #(.REQ_WIDTH(72), .MSG_WIDTH(520)) bus ();

  ipg_tx_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy));

  int vectors = 0;
  int miss    = 0;
  int lens [0:31];

  logic [71:0]   X1 = {READ_REQ, 64'h0123_4567_89ab_cdef};
  logic [71:0]   X2 = {WRITE_REQ, 64'hfedc_ba98_7654_3210};
  logic [519:0]  R  = {13{40'h01_2345_6789}};

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic collect(input string tag, input int maxc, input logic exp_src,
                         output int nch, output int tot, output logic [1023:0] acc,
                         output int first_at);
    logic        done;
    logic [55:0] pl;
    logic [55:0] pad;
    nch = 0; tot = 0; acc = '0; first_at = -1; done = 1'b0;
    for (int c = 1; c <= maxc && !done && nch < 32; c++) begin
      step();
      if (bus.tx_ipg_valid) begin
        if (first_at < 0) first_at = c;
        lens[nch] = int'(bus.tx_ipg_len);
        pl  = bus.tx_ipg_data[63:8];
        pad = pl << bus.tx_ipg_len;
        chk({tag, "_type"}, 64'(bus.tx_ipg_data[7:0]), 64'h1e);
        chk({tag, "_src"}, 64'(bus.tx_ipg_src), 64'(exp_src));
        chk({tag, "_pad"}, 64'(pad), 64'h0);
        acc = (acc << bus.tx_ipg_len) | 1024'(pl >> (56 - int'(bus.tx_ipg_len)));
        tot += int'(bus.tx_ipg_len);
        nch++;
        done = bus.tx_ipg_last;
      end
    end
    chk({tag, "_done"}, 64'(done), 64'h1);
  endtask

  initial begin
    int nch, tot, first_at, k;
    logic [1023:0] acc;
    logic bad;

    bus.req_valid = 0; bus.req_data = '0; bus.rep_valid = 0; bus.rep_data = '0;
    bus.slot_avail = 0; bus.slot_bits = '0;

    // reset state
    repeat (3) step();
    chk("rst_valid", 64'(bus.tx_ipg_valid), 0);
    chk("rst_data",  bus.tx_ipg_data, 0);
    chk("rst_len",   64'(bus.tx_ipg_len), 0);
    chk("rst_last",  64'(bus.tx_ipg_last), 0);
    chk("rst_src",   64'(bus.tx_ipg_src), 0);
    chk("rst_busy",  64'(busy), 0);

    // 1: 72-bit request at 56 bits/slot
    rst_n = 1; bus.req_valid = 1; bus.req_data = X1;
    bus.slot_avail = 1; bus.slot_bits = 6'd56;
    #1;
    chk("t1_req_ready", 64'(bus.req_ready), 1);
    chk("t1_rep_ready", 64'(bus.rep_ready), 0);
    step();
    chk("t1_busy", 64'(busy), 1);
    chk("t1_ready_send", 64'(bus.req_ready), 0);
    bus.req_valid = 0;
    collect("t1", 10, 1'b0, nch, tot, acc, first_at);
    chk("t1_latency", 64'(first_at), 1);
    chk("t1_nch", 64'(nch), 2);
    chk("t1_len0", 64'(lens[0]), 56);
    chk("t1_len1", 64'(lens[1]), 16);
    chk("t1_tot", 64'(tot), 72);
    chk("t1_payload", 64'(acc[71:0] == X1), 1);

    // 2: 520-bit reply, bubble before accept
    bus.rep_valid = 1; bus.rep_data = R;
    #1;
    chk("t2_bubble", 64'(bus.rep_ready), 0);
    step();
    chk("t2_rep_ready", 64'(bus.rep_ready), 1);
    step();
    bus.rep_valid = 0;
    collect("t2", 20, 1'b1, nch, tot, acc, first_at);
    chk("t2_nch", 64'(nch), 10);
    for (int i = 0; i < 9; i++) chk("t2_len", 64'(lens[i]), 56);
    chk("t2_len9", 64'(lens[9]), 16);
    chk("t2_tot", 64'(tot), 520);
    chk("t2_payload", 64'(acc[519:0] == R), 1);

    // 3: both valid from reset
    rst_n = 0; bus.req_valid = 1; bus.rep_valid = 1; bus.req_data = X1; bus.rep_data = R;
    step(); step();
    chk("t3_rst_ready", 64'(bus.req_ready), 0);
    rst_n = 1;
    #1;
    chk("t3_req_first", 64'(bus.req_ready), 1);
    chk("t3_rep_wait", 64'(bus.rep_ready), 0);
    step();
    collect("t3a", 10, 1'b0, nch, tot, acc, first_at);
    chk("t3a_nch", 64'(nch), 2);
    chk("t3_bubble_rep", 64'(bus.rep_ready), 0);
    chk("t3_bubble_req", 64'(bus.req_ready), 0);
    step();
    chk("t3_rep_next", 64'(bus.rep_ready), 1);
    chk("t3_req_hold", 64'(bus.req_ready), 0);
    step();
    collect("t3b", 20, 1'b1, nch, tot, acc, first_at);
    chk("t3b_nch", 64'(nch), 10);
    step();
    chk("t3_tie_req", 64'(bus.req_ready), 1);
    chk("t3_tie_rep", 64'(bus.rep_ready), 0);
    bus.req_valid = 0; bus.rep_valid = 0;

    // 4: slot sizes 10, 0, 63, 3 then remainder
    bus.req_valid = 1; bus.req_data = X2; bus.slot_avail = 0;
    step();
    bus.req_valid = 0; bus.slot_avail = 1; bus.slot_bits = 6'd10;
    step();
    chk("t4_v10", 64'(bus.tx_ipg_valid), 1);
    chk("t4_l10", 64'(bus.tx_ipg_len), 10);
    chk("t4_d10", bus.tx_ipg_data, {X2[71:62], 46'b0, 8'h1e});
    bus.slot_bits = 6'd0;
    step();
    chk("t4_v0", 64'(bus.tx_ipg_valid), 0);
    bus.slot_bits = 6'd63;
    step();
    chk("t4_l63", 64'(bus.tx_ipg_len), 56);
    chk("t4_d63", bus.tx_ipg_data, {X2[61:6], 8'h1e});
    bus.slot_bits = 6'd3;
    step();
    chk("t4_l3", 64'(bus.tx_ipg_len), 3);
    chk("t4_d3", bus.tx_ipg_data, {X2[5:3], 53'b0, 8'h1e});
    chk("t4_nolast", 64'(bus.tx_ipg_last), 0);
    bus.slot_bits = 6'd56;
    step();
    chk("t4_lrem", 64'(bus.tx_ipg_len), 3);
    chk("t4_drem", bus.tx_ipg_data, {X2[2:0], 53'b0, 8'h1e});
    chk("t4_last", 64'(bus.tx_ipg_last), 1);

    // 5: reset after chunk 4 of a reply
    step();
    bus.rep_valid = 1; bus.rep_data = R;
    #1;
    chk("t5_rep_ready", 64'(bus.rep_ready), 1);
    step();
    bus.rep_valid = 0;
    k = 0;
    for (int c = 0; c < 10 && k < 4; c++) begin
      step();
      if (bus.tx_ipg_valid) k++;
    end
    chk("t5_four", 64'(k), 4);
    rst_n = 0;
    step();
    chk("t5_valid", 64'(bus.tx_ipg_valid), 0);
    chk("t5_data", bus.tx_ipg_data, 0);
    chk("t5_len", 64'(bus.tx_ipg_len), 0);
    chk("t5_last", 64'(bus.tx_ipg_last), 0);
    chk("t5_src", 64'(bus.tx_ipg_src), 0);
    chk("t5_busy", 64'(busy), 0);
    rst_n = 1; bus.req_valid = 1; bus.req_data = X1;
    #1;
    chk("t5_req_ready", 64'(bus.req_ready), 1);
    step();
    bus.req_valid = 0;
    collect("t5", 10, 1'b0, nch, tot, acc, first_at);
    chk("t5_tot", 64'(tot), 72);
    chk("t5_payload", 64'(acc[71:0] == X1), 1);

    // 6: 100-cycle stall mid-message
    bus.req_valid = 1; bus.req_data = X2;
    step(); step();
    bus.req_data = X1;
    step();
    chk("t6_v1", 64'(bus.tx_ipg_valid), 1);
    chk("t6_d1", bus.tx_ipg_data, {X2[71:16], 8'h1e});
    bus.slot_avail = 0;
    bad = 0;
    repeat (100) begin
      step();
      if (bus.tx_ipg_valid || bus.req_ready) bad = 1;
    end
    chk("t6_quiet", 64'(bad), 0);
    bus.slot_avail = 1;
    step();
    chk("t6_v2", 64'(bus.tx_ipg_valid), 1);
    chk("t6_l2", 64'(bus.tx_ipg_len), 16);
    chk("t6_d2", bus.tx_ipg_data, {X2[15:0], 40'b0, 8'h1e});
    chk("t6_last", 64'(bus.tx_ipg_last), 1);
    bus.req_valid = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule
